imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 122 ++++++++++++
 tb/tb_imem_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Streams a program from a source FIFO into instruction memory, then releases the CPU.
// Two cycles per word (pop, then write); stalls in REQ with no timeout while the FIFO is empty.
module imem_loader #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] prog_len,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [31:0]      fifo_dout,
    output logic             mem_we,
    output logic [31:0]      mem_dir,
    output logic [31:0]      mem_data,
    output logic             cpu_run,
    output logic             busy,
    output logic [CNT_W-1:0] words_loaded
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WRITE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] eff_len;
    logic [31:0]      dir_q;
    logic [31:0]      dir_nxt;
    logic [31:0]      data_q;
    logic [31:0]      data_nxt;
    logic [31:0]      wr_addr;

    // Zero or oversized lengths fall back to a full-memory load, so addresses never wrap.
    assign eff_len = (prog_len == '0 || prog_len > DEPTH_C) ? DEPTH_C : prog_len;
    assign cnt_inc = words_loaded + CNT_W'(1);
    assign wr_addr = 32'({words_loaded, 2'b00});

    always_comb begin
        state_nxt  = state;
        len_nxt    = len_q;
        cnt_nxt    = words_loaded;
        dir_nxt    = dir_q;
        data_nxt   = data_q;
        fifo_rd_en = 1'b0;
        mem_we     = 1'b0;
        mem_dir    = dir_q;
        mem_data   = data_q;
        busy       = 1'b0;
        cpu_run    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    len_nxt   = eff_len;
                    cnt_nxt   = '0;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                busy = 1'b1;
                if (!fifo_empty) begin
                    fifo_rd_en = rst_n;
                    state_nxt  = WRITE;
                end
            end
            WRITE: begin
                busy = 1'b1;
                // Gated by rst_n so a reset in this cycle drops the popped word unwritten.
                mem_we    = rst_n;
                mem_dir   = wr_addr;
                mem_data  = fifo_dout;
                dir_nxt   = wr_addr;
                data_nxt  = fifo_dout;
                cnt_nxt   = cnt_inc;
                state_nxt = (cnt_inc == len_q) ? DONE : REQ;
            end
            DONE: begin
                cpu_run = 1'b1;
                if (start) begin
                    len_nxt   = eff_len;
                    cnt_nxt   = '0;
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            len_q        <= DEPTH_C;
            words_loaded <= '0;
            dir_q        <= '0;
            data_q       <= '0;
        end else begin
            state        <= state_nxt;
            len_q        <= len_nxt;
            words_loaded <= cnt_nxt;
            dir_q        <= dir_nxt;
            data_q       <= data_nxt;
        end
    end

    always_ff @(posedge clk) begin
        assert (!(fifo_rd_en && mem_we));
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a queue-based FIFO feeds the DUT and every write is
// compared against the expected address/word sequence derived from the load length.
module tb_imem_loader;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] prog_len;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [31:0]      fifo_dout = '0;
    logic             mem_we;
    logic [31:0]      mem_dir;
    logic [31:0]      mem_data;
    logic             cpu_run;
    logic             busy;
    logic [CNT_W-1:0] words_loaded;

    imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prog_len(prog_len),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .mem_we(mem_we), .mem_dir(mem_dir), .mem_data(mem_data),
        .cpu_run(cpu_run), .busy(busy), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    logic [31:0] fifo_mem [0:255];
    int          head = 0;
    int          tail = 0;
    assign fifo_empty = (head == tail);

    always @(posedge clk) begin
        if (fifo_rd_en === 1'b1 && head != tail) begin
            fifo_dout <= fifo_mem[head[7:0]];
            head      <= head + 1;
        end
    end

    int          n_checks   = 0;
    int          n_fail     = 0;
    int          conflicts  = 0;
    int          underflows = 0;
    logic [63:0] wr_log [$];
    logic [31:0] exp_q [$];

    always @(negedge clk) begin
        if (fifo_rd_en === 1'b1 && mem_we === 1'b1) conflicts++;
        if (fifo_rd_en === 1'b1 && fifo_empty) underflows++;
        if (mem_we === 1'b1) wr_log.push_back({mem_dir, mem_data});
    end

    task automatic push_word(input logic [31:0] w);
        fifo_mem[tail[7:0]] = w;
        tail = tail + 1;
        exp_q.push_back(w);
    endtask

    function automatic int eff_len(input int p);
        return (p == 0 || p > DEPTH) ? DEPTH : p;
    endfunction

    // Runs one load from IDLE/DONE and checks it against the expected write list.
    task automatic do_load(input int plen, input int gap, input bit mid_start, input string tag);
        int          eff;
        int          need;
        int          n;
        int          busy_bad;
        int          logged;
        bit          full;
        logic [63:0] got;
        logic [63:0] want;
        logic [31:0] last_w;
        eff  = eff_len(plen);
        need = eff - exp_q.size();
        if (need < 0) need = 0;
        full = (need == 0);
        wr_log.delete();

        start    = 1'b1;
        prog_len = plen[CNT_W-1:0];
        @(posedge clk); #1;
        start    = 1'b0;
        prog_len = CNT_W'($urandom_range(0, 15));
        n_checks++;
        if (cpu_run !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s entry: cpu_run=%b busy=%b, required cpu_run=0 busy=1", tag, cpu_run, busy);
        end

        n = 0;
        busy_bad = 0;
        while (cpu_run !== 1'b1 && n < 500) begin
            if (busy !== 1'b1) busy_bad++;
            if (need > 0 && (n % gap) == 0) begin
                push_word($urandom);
                need--;
            end
            if (mid_start && n == 1) begin
                start    = 1'b1;
                prog_len = 4'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;

        n_checks++;
        if (n >= 500) begin
            n_fail++;
            $display("FAIL %s timeout: cpu_run=%b after %0d cycles, required 1", tag, cpu_run, n);
        end
        n_checks++;
        if (busy_bad != 0) begin
            n_fail++;
            $display("FAIL %s busy_during_load: %0d low cycles, required 0", tag, busy_bad);
        end
        if (full) begin
            n_checks++;
            if (n != 2 * eff) begin
                n_fail++;
                $display("FAIL %s latency: %0d cycles, required %0d", tag, n, 2 * eff);
            end
        end
        logged = wr_log.size();
        n_checks++;
        if (logged != eff) begin
            n_fail++;
            $display("FAIL %s write_count: %0d, required %0d", tag, logged, eff);
        end
        last_w = '0;
        for (int i = 0; i < eff; i++) begin
            last_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            want   = {32'(4 * i), last_w};
            if (i < logged) begin
                got = wr_log[i];
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL %s write[%0d]: addr=%h data=%h, required addr=%h data=%h",
                             tag, i, got[63:32], got[31:0], want[63:32], want[31:0]);
                end
            end
        end
        n_checks++;
        if (words_loaded !== CNT_W'(eff) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_state: words_loaded=%0d busy=%b, required %0d and 0",
                     tag, words_loaded, busy, eff);
        end
        n_checks++;
        if (mem_dir !== 32'(4 * (eff - 1)) || mem_data !== last_w || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL %s hold: dir=%h data=%h we=%b, required dir=%h data=%h we=0",
                     tag, mem_dir, mem_data, mem_we, 32'(4 * (eff - 1)), last_w);
        end
        @(posedge clk); #1;
        n_checks++;
        if (cpu_run !== 1'b1 || wr_log.size() != logged) begin
            n_fail++;
            $display("FAIL %s stay_done: cpu_run=%b writes=%0d, required 1 and %0d",
                     tag, cpu_run, wr_log.size(), logged);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        prog_len = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({fifo_rd_en, mem_we, cpu_run, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: rd_en=%b we=%b run=%b busy=%b, required all 0",
                     fifo_rd_en, mem_we, cpu_run, busy);
        end
        n_checks++;
        if (mem_dir !== '0 || mem_data !== '0 || words_loaded !== '0) begin
            n_fail++;
            $display("FAIL reset_data: dir=%h data=%h cnt=%0d, required all 0",
                     mem_dir, mem_data, words_loaded);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || cpu_run !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b run=%b, required 0 0", busy, cpu_run);
        end
    endtask

    task automatic test_full_load();
        logic [31:0] w;
        for (int i = 1; i <= 8; i++) begin
            w = 32'(i * 17);
            push_word(w);
        end
        do_load(8, 1, 1'b0, "full_load");
    endtask

    task automatic test_starved();
        do_load(3, 5, 1'b0, "starved");
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 8; i++) push_word($urandom);
        do_load(0, 1, 1'b0, "clamp_len0");
        for (int i = 0; i < 8; i++) push_word($urandom);
        do_load(12, 1, 1'b0, "clamp_len12");
    endtask

    task automatic test_start_ignored();
        push_word($urandom);
        push_word($urandom);
        do_load(2, 1, 1'b1, "start_ignored");
    endtask

    task automatic test_reset_mid();
        wr_log.delete();
        for (int i = 0; i < 3; i++) push_word($urandom);
        start    = 1'b1;
        prog_len = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (fifo_rd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pop: rd_en=%b, required 1", fifo_rd_en);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_we: mem_we=%b, required 0", mem_we);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({fifo_rd_en, mem_we, cpu_run, busy} !== 4'b0000 || mem_dir !== '0 ||
            mem_data !== '0 || words_loaded !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: rd=%b we=%b run=%b busy=%b dir=%h data=%h cnt=%0d, required all 0",
                     fifo_rd_en, mem_we, cpu_run, busy, mem_dir, mem_data, words_loaded);
        end
        rst_n = 1'b1;
        n_checks++;
        if (wr_log.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_nowrite: %0d writes, required 0", wr_log.size());
        end
        void'(exp_q.pop_front());
        do_load(2, 1, 1'b0, "reload_after_reset");
    endtask

    task automatic test_reload_done();
        for (int i = 0; i < 3; i++) push_word($urandom);
        do_load(3, 1, 1'b0, "reload_from_done");
    endtask

    task automatic test_random();
        int plen;
        int pre;
        for (int it = 0; it < 6; it++) begin
            plen = $urandom_range(0, 15);
            pre  = $urandom_range(0, eff_len(plen));
            for (int i = 0; i < pre; i++) push_word($urandom);
            do_load(plen, $urandom_range(1, 5), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_starved();
        test_clamp();
        test_start_ignored();
        test_reset_mid();
        test_reload_done();
        test_random();
        n_checks++;
        if (conflicts != 0) begin
            n_fail++;
            $display("FAIL rd_we_overlap: %0d cycles, required 0", conflicts);
        end
        n_checks++;
        if (underflows != 0) begin
            n_fail++;
            $display("FAIL pop_when_empty: %0d cycles, required 0", underflows);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
